reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 117 +++++++++++
 tb/tb_reaction_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// reaction_timer: ms-resolution reaction-time game with random stimulus delay, foul and timeout detection
module reaction_timer #(
    parameter int TICKS_PER_MS = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_RT_MS    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] random,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic [13:0] rt_ms,
    output logic        rt_valid,
    output logic        foul,
    output logic        timeout,
    output logic        busy
);
    localparam int PW   = TICKS_PER_MS > 1 ? $clog2(TICKS_PER_MS) : 1;
    localparam int DMAX = MIN_DELAY_MS + 8191;
    localparam int MW   = $clog2((DMAX > MAX_RT_MS ? DMAX : MAX_RT_MS) + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d, delay_q, delay_d, ms_inc;
    logic [13:0]     rt_q, rt_d;
    logic            valid_q, valid_d, foul_q, foul_d, to_q, to_d;
    logic            start_q, stop_q, start_edge, stop_edge, tick;

    assign start_edge = start & ~start_q;
    assign stop_edge  = stop & ~stop_q;
    assign tick       = presc_q == PW'(TICKS_PER_MS - 1);
    assign ms_inc     = ms_q + 1'b1;
    assign presc_d    = (state_d != state_q || tick) ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        delay_d = delay_q;
        rt_d    = rt_q;
        valid_d = 1'b0;
        foul_d  = foul_q;
        to_d    = to_q;
        case (state_q)
            S_WAIT: begin
                if (stop_edge) begin
                    foul_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tick) begin
                    ms_d    = ms_inc >= delay_q ? '0 : ms_inc;
                    state_d = ms_inc >= delay_q ? S_ARMED : S_WAIT;
                end
            end
            S_ARMED: begin
                // A stop edge on the final tick still counts as a response
                if (stop_edge) begin
                    rt_d    = tick ? 14'(ms_inc) : 14'(ms_q);
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if (tick) begin
                    if (ms_inc >= MW'(MAX_RT_MS)) begin
                        rt_d    = 14'(MAX_RT_MS);
                        to_d    = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ms_d = ms_inc;
                    end
                end
            end
            default: begin
                if (start_edge) begin
                    delay_d = MW'(MIN_DELAY_MS) + MW'(random);
                    ms_d    = '0;
                    foul_d  = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            delay_q <= '0;
            rt_q    <= '0;
            valid_q <= 1'b0;
            foul_q  <= 1'b0;
            to_q    <= 1'b0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            delay_q <= delay_d;
            rt_q    <= rt_d;
            valid_q <= valid_d;
            foul_q  <= foul_d;
            to_q    <= to_d;
            start_q <= start;
            stop_q  <= stop;
        end
    end

    assign led      = state_q == S_ARMED;
    assign busy     = state_q == S_WAIT || state_q == S_ARMED;
    assign rt_ms    = rt_q;
    assign rt_valid = valid_q;
    assign foul     = foul_q;
    assign timeout  = to_q;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: timestamp-based reference model plus directed trials with literal expectations
module tb_reaction_timer;
    localparam int T    = 4;
    localparam int MIND = 2;
    localparam int MAXR = 20;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [12:0] random = '0;
    logic        led, rt_valid, foul, timeout, busy;
    logic [13:0] rt_ms;

    int vectors = 0, errors = 0;

    reaction_timer #(.TICKS_PER_MS(T), .MIN_DELAY_MS(MIND), .MAX_RT_MS(MAXR)) dut (
        .clk(clk), .rst(rst), .random(random), .start(start), .stop(stop),
        .led(led), .rt_ms(rt_ms), .rt_valid(rt_valid), .foul(foul),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a trial is a start edge at edge number e; the lamp turns on after
    // edge arm_e = e + T*delay and the response is the number of whole ms since.
    int  edge_n = 0, arm_e = 0, e_rt = 0;
    bit  trial_on = 0, e_valid = 0, e_foul = 0, e_to = 0, e_led = 0, ps = 1, pss = 1, seen = 0;
    bit  se, pe;

    always @(posedge clk) begin
        edge_n++;
        seen = 1;
        if (rst) begin
            trial_on = 0; e_rt = 0; e_valid = 0; e_foul = 0; e_to = 0; ps = 1; pss = 1;
        end else begin
            se = start && !ps;
            pe = stop && !pss;
            ps = start;
            pss = stop;
            e_valid = 0;
            if (trial_on) begin
                if (pe) begin
                    trial_on = 0;
                    if (edge_n <= arm_e) e_foul = 1;
                    else begin e_rt = (edge_n - arm_e) / T; e_valid = 1; end
                end else if (edge_n == arm_e + T * MAXR) begin
                    trial_on = 0; e_rt = MAXR; e_to = 1; e_valid = 1;
                end
            end else if (se) begin
                trial_on = 1; arm_e = edge_n + T * (MIND + int'(random)); e_foul = 0; e_to = 0;
            end
        end
        e_led = trial_on && edge_n >= arm_e;
    end

    always @(negedge clk) if (seen) begin
        chk("led", led, e_led);
        chk("busy", busy, trial_on);
        chk("rt_ms", rt_ms, e_rt);
        chk("rt_valid", rt_valid, e_valid);
        chk("foul", foul, e_foul);
        chk("timeout", timeout, e_to);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 300) begin
            cyc(1);
            n++;
        end
        chk("led_rise", led, 1);
    endtask

    int n;

    initial begin
        cyc(3);
        chk("reset_rt_ms", rt_ms, 0);
        chk("reset_led", led, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        cyc(2);
        // normal trial: delay 5 ms, response 5 ms after lamp
        random = 13'd3;
        press_start();
        wait_led(n);
        chk("led_delay_cycles", n, 20);
        cyc(19);
        stop = 1'b1;
        cyc(1);
        chk("normal_rt_valid", rt_valid, 1);
        chk("normal_rt_ms", rt_ms, 5);
        chk("normal_foul", foul, 0);
        chk("normal_timeout", timeout, 0);
        stop = 1'b0;
        cyc(3);
        // false start 3 ms into a 12 ms wait
        random = 13'd10;
        press_start();
        cyc(12);
        stop = 1'b1;
        cyc(1);
        chk("foul_set", foul, 1);
        chk("foul_rt_kept", rt_ms, 5);
        chk("foul_no_valid", rt_valid, 0);
        chk("foul_led", led, 0);
        cyc(2);
        stop = 1'b0;
        cyc(1);
        // re-trigger after foul, ignored start in WAIT, then timeout
        random = 13'd0;
        press_start();
        chk("retrig_foul_clear", foul, 0);
        chk("retrig_busy", busy, 1);
        random = 13'd7;
        cyc(2);
        press_start();
        n = 0;
        while (!rt_valid && n < 300) begin
            cyc(1);
            n++;
        end
        chk("timeout_valid", rt_valid, 1);
        chk("timeout_rt_ms", rt_ms, 20);
        chk("timeout_flag", timeout, 1);
        chk("timeout_led", led, 0);
        cyc(2);
        // tie: stop on the 20th armed tick
        random = 13'd0;
        press_start();
        wait_led(n);
        cyc(79);
        stop = 1'b1;
        cyc(1);
        chk("tie_valid", rt_valid, 1);
        chk("tie_rt_ms", rt_ms, 20);
        chk("tie_timeout", timeout, 0);
        cyc(2);
        // stop held through reset, then reset while armed
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        random = 13'd1;
        press_start();
        cyc(3);
        chk("held_no_foul", foul, 0);
        chk("held_busy", busy, 1);
        wait_led(n);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("abort_led", led, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rt_ms", rt_ms, 0);
        chk("abort_valid", rt_valid, 0);
        rst = 1'b0;
        stop = 1'b0;
        cyc(2);
        // simultaneous start and stop in IDLE: start wins
        random = 13'd2;
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("both_busy", busy, 1);
        chk("both_foul", foul, 0);
        cyc(3);
        stop = 1'b1;
        cyc(1);
        chk("late_foul", foul, 1);
        stop = 1'b0;
        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
